// File: rtl/xorshift_gen.sv
// Xorshift pseudo-random word generator with valid/ready output, seed load and a busy skip-ahead mode.
// Optional transfer counter output word_cnt is enabled by defining XORSHIFT_WORD_CNT_EN.
module xorshift_gen #(
  parameter int WIDTH = 32,
  parameter int SHIFT_A = 13,
  parameter int SHIFT_B = 17,
  parameter int SHIFT_C = 5,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h2545F491)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             skip_req,
  input  logic [15:0]      skip_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef XORSHIFT_WORD_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  typedef enum logic {RUN, SKIP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s, s_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic             skip_go;
  logic             xfer;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x ^ (x << SHIFT_A);
    y = y ^ (y >> SHIFT_B);
    y = y ^ (y << SHIFT_C);
    return y;
  endfunction

  assign out       = s;
  assign busy      = (state == SKIP);
  assign out_valid = (state == RUN) && en;

  // A skip request outranks a simultaneous handshake; the consumer's word is not consumed then.
  assign skip_go = (state == RUN) && skip_req && (skip_count != 16'd0) && !seed_load;
  assign xfer    = out_valid && out_ready && !seed_load && !skip_go;

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    cnt_nxt   = cnt;
    if (seed_load) begin
      s_nxt     = (seed == '0) ? DEFAULT_SEED : seed;
      state_nxt = RUN;
      cnt_nxt   = 16'd0;
    end else if (state == SKIP) begin
      s_nxt   = step(s);
      cnt_nxt = cnt - 16'd1;
      if (cnt == 16'd1) begin
        state_nxt = RUN;
      end
    end else if (skip_go) begin
      state_nxt = SKIP;
      cnt_nxt   = skip_count;
    end else if (xfer) begin
      s_nxt = step(s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      s     <= DEFAULT_SEED;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef XORSHIFT_WORD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= 32'd0;
    end else if (seed_load) begin
      word_cnt <= 32'd0;
    end else if (xfer) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xorshift_gen.sv
// Directed and randomized checks of xorshift_gen (WIDTH=32) against an arithmetic reference model.
module tb_xorshift_gen;

  localparam logic [31:0] DEF = 32'h2545F491;

  logic        clk;
  logic        rst;
  logic        en;
  logic        seed_load;
  logic [31:0] seed;
  logic        skip_req;
  logic [15:0] skip_count;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out;
  logic        busy;
`ifdef XORSHIFT_WORD_CNT_EN
  logic [31:0] word_cnt;
`endif

  int checks;
  int passed;

  logic [31:0] m_s;
  int          m_skip;
  logic [31:0] m_wc;

  xorshift_gen dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .seed_load(seed_load),
    .seed(seed),
    .skip_req(skip_req),
    .skip_count(skip_count),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out(out),
    .busy(busy)
`ifdef XORSHIFT_WORD_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference step with shifts expressed as multiply/divide by powers of two.
  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    logic [63:0] t;
    y = x;
    t = 64'(y) * 64'd8192;
    y = y ^ t[31:0];
    y = y ^ (y / 32'd131072);
    t = 64'(y) * 64'd32;
    y = y ^ t[31:0];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s    = DEF;
    m_skip = 0;
    m_wc   = 32'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (seed_load) begin
      m_s    = (seed == 32'd0) ? DEF : seed;
      m_skip = 0;
      m_wc   = 32'd0;
    end else if (m_skip > 0) begin
      m_s    = ref_step(m_s);
      m_skip = m_skip - 1;
    end else if (skip_req && skip_count != 16'd0) begin
      m_skip = int'(skip_count);
    end else if (en && out_ready) begin
      m_s  = ref_step(m_s);
      m_wc = m_wc + 32'd1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"}, out, m_s);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (m_skip == 0) && en});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_skip > 0});
`ifdef XORSHIFT_WORD_CNT_EN
    chk({tag, ".word_cnt"}, word_cnt, m_wc);
`endif
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    rst        = 1'b1;
    en         = 1'b1;
    seed_load  = 1'b0;
    seed       = 32'd0;
    skip_req   = 1'b0;
    skip_count = 16'd0;
    out_ready  = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("reset.out", out, DEF);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd1);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    cycle("reset_hold");
    rst = 1'b0;
    cycle("idle_bp");

    // Seed 1 then free-running sequence
    seed_load = 1'b1;
    seed      = 32'd1;
    cycle("seed1");
    seed_load = 1'b0;
    chk("seed1.word", out, 32'h00000001);
    out_ready = 1'b1;
    cycle("seq1");
    chk("seq1.word", out, 32'h00042021);
    cycle("seq2");
    chk("seq2.word", out, 32'h04080601);

    // Zero seed falls back to the default
    seed_load = 1'b1;
    seed      = 32'd0;
    cycle("seed0");
    seed_load = 1'b0;
    chk("seed0.word", out, DEF);

    // Backpressure holds the word
    seed_load = 1'b1;
    seed      = 32'd1;
    out_ready = 1'b0;
    cycle("seed1b");
    seed_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("hold");
      chk("hold.word", out, 32'h00000001);
    end
    out_ready = 1'b1;
    cycle("release");
    chk("release.word", out, 32'h00042021);

    // Skip of 2 steps
    seed_load = 1'b1;
    seed      = 32'd1;
    out_ready = 1'b0;
    cycle("seed1c");
    seed_load  = 1'b0;
    skip_req   = 1'b1;
    skip_count = 16'd2;
    cycle("skip_a");
    skip_req = 1'b0;
    chk("skip_a.busy", {31'd0, busy}, 32'd1);
    chk("skip_a.valid", {31'd0, out_valid}, 32'd0);
    cycle("skip_b");
    chk("skip_b.busy", {31'd0, busy}, 32'd1);
    cycle("skip_done");
    chk("skip_done.word", out, 32'h04080601);
    chk("skip_done.valid", {31'd0, out_valid}, 32'd1);

    // Skip of zero is ignored
    skip_req   = 1'b1;
    skip_count = 16'd0;
    cycle("skip0");
    skip_req = 1'b0;
    chk("skip0.busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-skip
    out_ready  = 1'b1;
    skip_req   = 1'b1;
    skip_count = 16'd100;
    cycle("skip100");
    skip_req = 1'b0;
    for (int i = 0; i < 10; i++) cycle("skip100_run");
    chk("skip100.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.busy", {31'd0, busy}, 32'd0);
    chk("async_rst.out", out, DEF);
`ifdef XORSHIFT_WORD_CNT_EN
    chk("async_rst.word_cnt", word_cnt, 32'd0);
`endif
    cycle("rst_hold");
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 1) != 0);
      seed_load  = ($urandom_range(0, 31) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      skip_req   = ($urandom_range(0, 15) == 0);
      skip_count = 16'($urandom_range(0, 6));
      cycle("rand");
      checks++;
      assert (out !== 32'd0) passed++;
      else $error("FAIL rand.nonzero: observed %08h expected nonzero", out);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
